// File: rtl/seven_seg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam logic [3:0] BLANK_CODE   = 4'hF;
    localparam int         NUM_COLS     = 8;
    localparam logic [2:0] COL_ONES     = 3'd0;
    localparam logic [2:0] COL_TENS     = 3'd1;
    localparam logic [2:0] COL_HUNDREDS = 3'd2;
    localparam logic [2:0] COL_CANDY    = 3'd4;

    // One double-dabble step on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[8+4*n +: 4] >= 4'd5) begin
                t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Leading-zero blanking: tens hides only when hundreds is also zero.
    function automatic logic [3:0] col_code(input logic [2:0] idx,
                                            input logic [3:0] hun,
                                            input logic [3:0] ten,
                                            input logic [3:0] one,
                                            input logic [2:0] candy);
        logic [3:0] code;
        code = BLANK_CODE;
        case (idx)
            COL_ONES:     code = one;
            COL_TENS:     code = (hun == 4'd0 && ten == 4'd0) ? BLANK_CODE : ten;
            COL_HUNDREDS: code = (hun == 4'd0) ? BLANK_CODE : hun;
            COL_CANDY:    code = {1'b0, candy};
            default:      code = BLANK_CODE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one double-dabble step per cycle.
// start accepted when idle; done pulses on the 8th step with bcd_o valid in that cycle.
module bin2bcd_seq
    import seven_seg_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_o  = 1'b0;
        if (run_q) begin
            shift_d = dd_step(shift_q);
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d  = 1'b0;
                done_o = 1'b1;
            end
        end else if (start_i) begin
            shift_d = {12'd0, bin_i};
            cnt_d   = 3'd0;
            run_d   = 1'b1;
        end
    end

    // Post-step value, so the result is usable on the same edge done is seen.
    assign bcd_o = shift_d[19:8];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Captures sum/candy on load, converts to BCD over 8 cycles, and scans 8 columns.
// Display holds the last committed values during conversion; load is ignored while busy.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
)
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] sum_i,
    input  logic [2:0] candy_sum_i,
    output logic       busy_o,
    output logic [7:0] display_column_o,
    output logic [3:0] digit_o
);

    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          IDX_W   = $clog2(NUM_COLS);

    state_e               state_q, state_d;
    logic                 conv_start, conv_done;
    logic [11:0]          conv_bcd;
    logic [3:0]           hun_q, ten_q, one_q;
    logic [2:0]           candy_q, pend_candy_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 scan_wrap;
    logic [NUM_COLS-1:0]  col_q, col_d;
    logic [3:0]           digit_q, digit_d;

    bin2bcd_seq u_bcd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (conv_start),
        .bin_i   (sum_i),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            SHOW: begin
                if (load_i) begin
                    conv_start = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = SHOW;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // Column and digit are computed from the same next index so they never disagree.
    always_comb begin
        scan_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
        presc_d   = scan_wrap ? '0 : presc_q + PRESC_W'(1);
        idx_d     = scan_wrap ? idx_q + IDX_W'(1) : idx_q;
        col_d     = ~(NUM_COLS'(1) << idx_d);
        digit_d   = col_code(idx_d, hun_q, ten_q, one_q, candy_q);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= SHOW;
            hun_q        <= '0;
            ten_q        <= '0;
            one_q        <= '0;
            candy_q      <= '0;
            pend_candy_q <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            col_q        <= ~NUM_COLS'(1);
            digit_q      <= 4'h0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (scan_wrap) begin
                col_q   <= col_d;
                digit_q <= digit_d;
            end
            if (conv_start) begin
                pend_candy_q <= candy_sum_i;
            end
            if (conv_done) begin
                hun_q   <= conv_bcd[11:8];
                ten_q   <= conv_bcd[7:4];
                one_q   <= conv_bcd[3:0];
                candy_q <= pend_candy_q;
            end
        end
    end

    assign busy_o           = (state_q == CONV);
    assign display_column_o = col_q;
    assign digit_o          = digit_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Scan and update controller for the vending machine's 8-column multiplexed seven-segment display. It captures the running coin `sum` and `candy_sum` on a load strobe and converts `sum` to BCD sequentially. It then time-multiplexes the columns, presenting one 4-bit digit code per active column to the segment decoder. It sits between the vending FSM and the segment decoder inside `seven_seg_top`.

## Interface
- `SCAN_DIV`, 50000: clk cycles per column dwell; 1 kHz per column at a 50 MHz clk. Minimum 1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk` rising edge.
- `load` in 1: capture request for `sum`/`candy_sum`; honoured only when idle.
- `sum` in 8: unsigned coin total, 0..255.
- `candy_sum` in 3: candy count, 0..7.
- `busy` out 1: high while a BCD conversion is in progress.
- `display_column` out 8: active-low one-hot column enable.
- `digit` out 4: code for the active column. 0..9 is a BCD digit; 4'hF means blank.

## Operation
- FSM states:
  - SHOW: idle, scanning.
  - CONV: double-dabble conversion in progress.
- Reset (`reset`=0 at an edge) has priority over everything:
  - state becomes SHOW;
  - committed BCD and candy registers, shift registers, prescaler, and column index all become 0.
- SHOW, `load`=1:
  - capture `sum` into the shift register and `candy_sum` into a pending register;
  - clear the bit counter; go to CONV.
- CONV:
  - each cycle performs one double-dabble step: add 3 to any BCD nibble ≥5, then shift left by 1;
  - 8 steps in total;
  - on the 8th step edge, commit hundreds/tens/ones and the pending candy value to the display registers, and return to SHOW.
- `load` in CONV is ignored, not queued.
- The display keeps showing the previous committed values throughout CONV, so no partial digits are ever shown.
- Column map, where idx 0 is the rightmost column:
  - 0: ones.
  - 1: tens, blanked when hundreds = 0 and tens = 0.
  - 2: hundreds, blanked when hundreds = 0.
  - 4: `{1'b0, candy}`.
  - 3, 5, 6, 7: blank (4'hF).
- Scanning runs continuously in every state:
  - prescaler counts 0..SCAN_DIV-1 and wraps;
  - on wrap, the column index increments mod 8;
  - `display_column` = ~(1 << idx);
  - `digit` is the mapped code for idx.

## Timing
- Reset values:
  - `busy` = 0;
  - `display_column` = 8'hFE;
  - `digit` = 4'h0 (ones of zero).
- Conversion latency:
  - `load` sampled at edge t0 → `busy` high from t0 through t0+8 (exactly 8 cycles);
  - new values committed at edge t0+8, when `busy` falls;
  - they are visible on the next column update.
- `load`=1 at edge t0+8 (the commit edge) is ignored, because state is still CONV at that edge. `load` at t0+9 is accepted.
- `display_column` and `digit` are both registered and change on the same edge, so they never mismatch.
- Column dwell is exactly SCAN_DIV cycles; with SCAN_DIV=1 the column advances every cycle.
- Column wrap goes from 8'h7F to 8'hFE with no gap cycle.
- Prescaler width is $clog2(SCAN_DIV), minimum 1 bit.
- Shift register is 20 bits: 12 BCD + 8 binary. BCD nibbles never exceed 9 after any step.

## Structure
- Shared package/include `seven_seg_pkg` holds:
  - state encoding (SHOW, CONV);
  - `BLANK_CODE` = 4'hF;
  - `NUM_COLS` = 8;
  - column index constants (COL_ONES, COL_TENS, COL_HUNDREDS, COL_CANDY).
- Sub-module `bin2bcd_seq` contains the 20-bit double-dabble shift register and its 3-bit step counter. It has a start/done handshake, and `done` is a 1-cycle pulse on the 8th step.
- Top level holds the FSM, commit registers, prescaler, column counter, and digit mux.

## Test plan
1. **Reset.** SCAN_DIV=4; `reset`=0 for 2 cycles → `display_column`=8'hFE, `digit`=0, `busy`=0; after release, the column advances every 4 cycles.
2. **Full conversion.** `load` with `sum`=255, `candy_sum`=5 → `busy` high exactly 8 cycles. One scan of columns 0..7 then yields `digit` 5,5,2,F,5,F,F,F.
3. **Blanking.** `sum`=7 → columns 0..2 show 7,F,F. `sum`=100 → 0,0,1. `sum`=50 → 0,5,F.
4. **Load collision.** `load` held high through CONV with `sum` changed to 9 mid-conversion → result still reflects the first capture. `load` at the commit edge is ignored; `load` one cycle later is accepted and converts 9.
5. **Reset mid-conversion.** Assert `reset` at CONV step 4 → next edge gives `busy`=0, all digits back to zero, `display_column`=8'hFE.
6. **Scan wrap.** SCAN_DIV=1, run 16 cycles → `display_column` walks FE, FD, … 7F, FE. `digit` matches the column map on every cycle, including while CONV is active.
